// File: rtl/eq_fir_sequencer.sv
// Sequencer for the equalizer FIR banks: owns the circular sample-queue pointers and runs one convolution pass per sample.
// Optional sticky overrun flag and its clear input are built when SEQ_OVERRUN_EN is defined.
module eq_fir_sequencer #(
  parameter int TAPS     = 1021,
  parameter int ADDR_W   = 10,
  parameter int PIPE_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              new_smpl_i,
`ifdef SEQ_OVERRUN_EN
  input  logic              ovr_clr_i,
`endif
  output logic              queue_we_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic              sequencing_o,
  output logic              filt_valid_o,
  output logic              busy_o
`ifdef SEQ_OVERRUN_EN
  ,
  output logic              overrun_o
`endif
);

  localparam int CNT_W  = $clog2(TAPS + PIPE_LAT);
  localparam int FILL_W = $clog2(TAPS + 1);

  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(TAPS - 1 + PIPE_LAT);
  localparam logic [CNT_W-1:0]  LAST_RD  = CNT_W'(TAPS - 1);
  localparam logic [FILL_W-1:0] FULL     = FILL_W'(TAPS);
  localparam logic [ADDR_W-1:0] TAPS_A   = ADDR_W'(TAPS);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  wrAddr_q, wrAddr_d;
  logic [ADDR_W-1:0]  rdAddr_q, rdAddr_d;
  logic [CNT_W-1:0]   passCnt_q, passCnt_d;
  logic [FILL_W-1:0]  fillCnt_q, fillCnt_d;
  logic               startPass;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      wrAddr_q  <= '0;
      rdAddr_q  <= '0;
      passCnt_q <= '0;
      fillCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      wrAddr_q  <= wrAddr_d;
      rdAddr_q  <= rdAddr_d;
      passCnt_q <= passCnt_d;
      fillCnt_q <= fillCnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    wrAddr_d     = wrAddr_q;
    rdAddr_d     = rdAddr_q;
    passCnt_d    = passCnt_q;
    fillCnt_d    = fillCnt_q;
    startPass    = 1'b0;
    sequencing_o = 1'b0;
    filt_valid_o = 1'b0;
    busy_o       = 1'b0;

    // Samples are always written, even mid-pass; only the pass trigger is state dependent.
    if (new_smpl_i) begin
      wrAddr_d = wrAddr_q + ADDR_W'(1);
      if (fillCnt_q != FULL) begin
        fillCnt_d = fillCnt_q + FILL_W'(1);
      end
    end

    unique case (state_q)
      IDLE: begin
        startPass = new_smpl_i && (fillCnt_d == FULL);
        if (startPass) begin
          state_d   = RUN;
          rdAddr_d  = wrAddr_q + ADDR_W'(1) - TAPS_A;
          passCnt_d = '0;
        end
      end
      RUN: begin
        sequencing_o = 1'b1;
        busy_o       = 1'b1;
        // Address stops at the newest sample; the tail cycles only cover ROM latency.
        if (passCnt_q < LAST_RD) begin
          rdAddr_d = rdAddr_q + ADDR_W'(1);
        end
        if (passCnt_q == LAST_CNT) begin
          state_d = DONE;
        end else begin
          passCnt_d = passCnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        filt_valid_o = 1'b1;
        busy_o       = 1'b1;
        state_d      = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign queue_we_o = new_smpl_i;
  assign wr_addr_o  = wrAddr_q;
  assign rd_addr_o  = rdAddr_q;

`ifdef SEQ_OVERRUN_EN
  logic overrun_q, overrun_d;

  // A new set takes priority over a simultaneous clear.
  always_comb begin
    overrun_d = overrun_q;
    if (new_smpl_i && busy_o) begin
      overrun_d = 1'b1;
    end else if (ovr_clr_i) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
    end
  end

  assign overrun_o = overrun_q;
`endif

endmodule

// File: tb/tb_eq_fir_sequencer.sv
// Self-checking bench for eq_fir_sequencer: a pass-position model checked every cycle plus hand-computed pass checks.
module tb_eq_fir_sequencer;

  localparam int TAPS     = 1021;
  localparam int ADDR_W   = 10;
  localparam int PIPE_LAT = 1;
  localparam int DEPTH    = 1 << ADDR_W;
  localparam int PASS_LEN = TAPS + PIPE_LAT;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              newSmpl = 1'b0;
  logic              queueWe;
  logic [ADDR_W-1:0] wrAddr;
  logic [ADDR_W-1:0] rdAddr;
  logic              sequencing;
  logic              filtValid;
  logic              busy;
`ifdef SEQ_OVERRUN_EN
  logic              ovrClr = 1'b0;
  logic              overrun;
`endif

  int nVec = 0;
  int nErr = 0;
  bit cmpEn = 1'b0;
  int seqSeen = 0;
  int filtSeen = 0;

  // Model state: position within a pass (0 = idle, 1..PASS_LEN = run, PASS_LEN+1 = done).
  int mWr, mFill, mPos, mStart, mRd;
  bit mOvr;

  eq_fir_sequencer #(
    .TAPS    (TAPS),
    .ADDR_W  (ADDR_W),
    .PIPE_LAT(PIPE_LAT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .new_smpl_i  (newSmpl),
`ifdef SEQ_OVERRUN_EN
    .ovr_clr_i   (ovrClr),
`endif
    .queue_we_o  (queueWe),
    .wr_addr_o   (wrAddr),
    .rd_addr_o   (rdAddr),
    .sequencing_o(sequencing),
    .filt_valid_o(filtValid),
    .busy_o      (busy)
`ifdef SEQ_OVERRUN_EN
    ,
    .overrun_o   (overrun)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin : model
    int pos, wr, fill, start, rd, off;
    bit ovr, idle;
    if (rst) begin
      mWr <= 0; mFill <= 0; mPos <= 0; mStart <= 0; mRd <= 0; mOvr <= 1'b0;
    end else begin
      pos = mPos; wr = mWr; fill = mFill; start = mStart; rd = mRd; ovr = mOvr;
      idle = (pos == 0);
      if (pos == PASS_LEN + 1) pos = 0;
      else if (pos != 0) pos++;
      if (newSmpl === 1'b1) begin
        if (idle && fill + 1 >= TAPS) begin
          start = (((wr + 1 - TAPS) % DEPTH) + DEPTH) % DEPTH;
          pos = 1;
        end
        wr = (wr + 1) % DEPTH;
        if (fill < TAPS) fill++;
      end
`ifdef SEQ_OVERRUN_EN
      if (newSmpl === 1'b1 && !idle) ovr = 1'b1;
      else if (ovrClr === 1'b1) ovr = 1'b0;
`endif
      if (pos >= 1) begin
        off = (pos - 1 < TAPS - 1) ? pos - 1 : TAPS - 1;
        rd = (start + off) % DEPTH;
      end
      mPos <= pos; mWr <= wr; mFill <= fill; mStart <= start; mRd <= rd; mOvr <= ovr;
    end
  end

  always @(negedge clk) begin
    if (cmpEn) begin
      checkOutput("sequencing", sequencing, (mPos >= 1 && mPos <= PASS_LEN));
      checkOutput("filt_valid", filtValid, (mPos == PASS_LEN + 1));
      checkOutput("busy", busy, (mPos != 0));
      checkOutput("wr_addr", wrAddr, mWr);
      checkOutput("rd_addr", rdAddr, mRd);
      checkOutput("queue_we", queueWe, newSmpl);
`ifdef SEQ_OVERRUN_EN
      checkOutput("overrun", overrun, mOvr);
`endif
      if (sequencing === 1'b1) seqSeen++;
      if (filtValid === 1'b1) filtSeen++;
    end
  end

  task automatic applyStimulus(input int nPulses, input int gap);
    for (int p = 0; p < nPulses; p++) begin
      @(posedge clk); #1 newSmpl = 1'b1;
      @(posedge clk); #1 newSmpl = 1'b0;
      repeat (gap - 2) @(posedge clk);
    end
  endtask

  // Triggers a pass on the first cycle, optionally injects extra samples mid-pass, and measures the pass shape.
  task automatic runPass(input int expFirst, input int midStart, input int midCount,
                         input int window, input bit expWrap, input string tag);
    int len, filt, first, prev;
    bit wrapSeen;
    len = 0; filt = 0; first = -1; prev = -1; wrapSeen = 1'b0;
    for (int i = 0; i < window; i++) begin
      @(posedge clk); #1;
      newSmpl = (i == 0) || (midCount > 0 && i >= midStart && i < midStart + 2 * midCount
                             && ((i - midStart) % 2 == 0));
      @(negedge clk);
      if (sequencing === 1'b1) begin
        len++;
        if (first < 0) first = int'(rdAddr);
        if (prev == DEPTH - 1 && rdAddr == 0) wrapSeen = 1'b1;
        prev = int'(rdAddr);
      end
      if (filtValid === 1'b1) filt++;
    end
    checkOutput({tag, "_seq_len"}, len, 1022);
    checkOutput({tag, "_first_rd"}, first, expFirst);
    checkOutput({tag, "_filt_pulses"}, filt, 1);
    if (expWrap) checkOutput({tag, "_rd_wrap"}, wrapSeen, 1);
  endtask

  initial begin
    int s0, f0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 cmpEn = 1'b1;
    @(negedge clk);
    checkOutput("rst_wr", wrAddr, 0);
    checkOutput("rst_rd", rdAddr, 0);
    checkOutput("rst_seq", sequencing, 0);
    checkOutput("rst_filt", filtValid, 0);
    checkOutput("rst_busy", busy, 0);
    @(posedge clk); #1 rst = 1'b0;

    s0 = seqSeen; f0 = filtSeen;
    applyStimulus(1020, 2);
    @(negedge clk);
    checkOutput("fill_wr", wrAddr, 1020);
    checkOutput("fill_no_seq", seqSeen - s0, 0);
    checkOutput("fill_no_filt", filtSeen - f0, 0);

    runPass(0, 0, 0, 1100, 1'b0, "first");
    runPass(1, 500, 10, 1100, 1'b0, "ovr");
`ifdef SEQ_OVERRUN_EN
    @(negedge clk);
    checkOutput("ovr_set", overrun, 1);
    @(posedge clk); #1 ovrClr = 1'b1;
    @(posedge clk); #1 ovrClr = 1'b0;
    @(negedge clk);
    checkOutput("ovr_cleared", overrun, 0);
`endif
    runPass(12, 0, 0, 1100, 1'b1, "wrap");

    @(posedge clk); #1 newSmpl = 1'b1;
    @(posedge clk); #1 newSmpl = 1'b0;
    repeat (299) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst_seq", sequencing, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_wr", wrAddr, 0);
    checkOutput("midrst_filt", filtValid, 0);
    @(posedge clk); #1 rst = 1'b0;

    s0 = seqSeen; f0 = filtSeen;
    applyStimulus(1020, 2);
    @(negedge clk);
    checkOutput("refill_wr", wrAddr, 1020);
    checkOutput("refill_no_seq", seqSeen - s0, 0);
    checkOutput("refill_no_filt", filtSeen - f0, 0);
    runPass(0, 0, 0, 1100, 1'b0, "refill");

    runPass(1, 0, 0, 1024, 1'b0, "b2b0");
    runPass(2, 0, 0, 1024, 1'b0, "b2b1");
    runPass(3, 0, 0, 1024, 1'b0, "b2b2");
`ifdef SEQ_OVERRUN_EN
    checkOutput("b2b_no_ovr", overrun, 0);
`endif

    repeat (5) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

  initial begin
    #2000000;
    nErr++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
